// File: rtl/program_loader.sv
// ICSP-style serial programming front end: 6-bit commands and 16-bit frames on PGC/PGD,
// drives the program memory write/read port and holds the CPU in reset while programming.
module program_loader #(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned INSTR_WIDTH = 14,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_en,
    input  logic                   pgc,
    input  logic                   pgd_in,
    output logic                   pgd_out,
    output logic                   pgd_oe,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_wr_en,
    output logic [INSTR_WIDTH-1:0] mem_wr_data,
    output logic                   mem_rd_en,
    input  logic [INSTR_WIDTH-1:0] mem_rd_data
);
    localparam int unsigned FRAME_W = INSTR_WIDTH + 2;
    localparam int unsigned CMD_W   = 6;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam int unsigned WAIT_W  = $clog2(RD_LATENCY + 2);

    localparam logic [CMD_W-1:0] CMD_LOAD_DATA  = 6'h02;
    localparam logic [CMD_W-1:0] CMD_READ_DATA  = 6'h04;
    localparam logic [CMD_W-1:0] CMD_INC_ADDR   = 6'h06;
    localparam logic [CMD_W-1:0] CMD_BEGIN_PROG = 6'h08;
    localparam logic [CMD_W-1:0] CMD_RESET_ADDR = 6'h16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LOAD,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_SHIFT
    } state_t;

    state_t state, state_d;

    logic [1:0] prog_sync;
    logic [2:0] pgc_sync;
    logic [1:0] pgd_sync;
    logic       prog_s, pgd_s, pgc_rise, pgc_fall;

    logic [FRAME_W-1:0]     shift_reg, shift_reg_d, shift_in;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_d;
    logic [WAIT_W-1:0]      rd_wait_cnt, rd_wait_cnt_d;
    logic                   cmd_rdy, cmd_rdy_d;
    logic [CMD_W-1:0]       cmd;
    logic                   cmd_last, frame_last, rd_done;
    logic                   pgd_out_d, pgd_oe_d, cpu_hold_d, busy_d;
    logic                   mem_wr_en_d, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [INSTR_WIDTH-1:0] mem_wr_data_d;

    // Pin synchronizers; pgc and pgd share the same depth so data lines up with the edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog_sync <= '0;
            pgc_sync  <= '0;
            pgd_sync  <= '0;
        end else begin
            prog_sync <= {prog_sync[0], prog_en};
            pgc_sync  <= {pgc_sync[1:0], pgc};
            pgd_sync  <= {pgd_sync[0], pgd_in};
        end
    end

    assign prog_s     = prog_sync[1];
    assign pgd_s      = pgd_sync[1];
    assign pgc_rise   = pgc_sync[1] & ~pgc_sync[2];
    assign pgc_fall   = ~pgc_sync[1] & pgc_sync[2];
    assign shift_in   = {pgd_s, shift_reg[FRAME_W-1:1]};
    assign cmd        = shift_reg[FRAME_W-1 -: CMD_W];
    assign cmd_last   = (bit_cnt == CNT_W'(CMD_W - 1));
    assign frame_last = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign rd_done    = (rd_wait_cnt == WAIT_W'(RD_LATENCY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state; losing prog_en overrides everything
    always_comb begin
        state_d = state;
        if (!prog_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (cmd_rdy) begin
                        case (cmd)
                            CMD_LOAD_DATA:  state_d = ST_LOAD;
                            CMD_READ_DATA:  state_d = ST_RD_WAIT;
                            CMD_BEGIN_PROG: state_d = ST_WRITE;
                            default:        state_d = ST_CMD;
                        endcase
                    end
                end
                ST_LOAD:     if (pgc_fall && frame_last) state_d = ST_CMD;
                ST_WRITE:    state_d = ST_CMD;
                ST_RD_WAIT:  if (rd_done) state_d = ST_RD_SHIFT;
                ST_RD_SHIFT: if (pgc_fall && frame_last) state_d = ST_CMD;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        shift_reg_d   = shift_reg;
        bit_cnt_d     = bit_cnt;
        rd_wait_cnt_d = rd_wait_cnt;
        cmd_rdy_d     = 1'b0;
        mem_addr_d    = mem_addr;
        mem_wr_data_d = mem_wr_data;
        pgd_out_d     = pgd_out;

        if (!prog_s) begin
            bit_cnt_d     = '0;
            rd_wait_cnt_d = '0;
        end else begin
            case (state)
                ST_IDLE: mem_addr_d = '0;
                ST_CMD: begin
                    if (cmd_rdy) begin
                        if (cmd == CMD_INC_ADDR)   mem_addr_d = mem_addr + ADDR_WIDTH'(1);
                        if (cmd == CMD_RESET_ADDR) mem_addr_d = '0;
                    end else if (pgc_fall) begin
                        shift_reg_d = shift_in;
                        if (cmd_last) begin
                            bit_cnt_d = '0;
                            cmd_rdy_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (pgc_fall) begin
                        shift_reg_d = shift_in;
                        if (frame_last) begin
                            bit_cnt_d     = '0;
                            mem_wr_data_d = shift_in[FRAME_W-2:1];
                        end else begin
                            bit_cnt_d = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_done) begin
                        rd_wait_cnt_d = '0;
                        shift_reg_d   = {1'b0, mem_rd_data, 1'b0};
                    end else begin
                        rd_wait_cnt_d = rd_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_RD_SHIFT: begin
                    if (pgc_rise) begin
                        pgd_out_d   = shift_reg[0];
                        shift_reg_d = {1'b0, shift_reg[FRAME_W-1:1]};
                    end
                    if (pgc_fall) begin
                        bit_cnt_d = frame_last ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (state_d != ST_RD_SHIFT) pgd_out_d = 1'b0;
        pgd_oe_d    = (state_d == ST_RD_SHIFT);
        cpu_hold_d  = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_CMD);
        mem_wr_en_d = (state_d == ST_WRITE);
        mem_rd_en_d = (state_d == ST_RD_WAIT) && (rd_wait_cnt_d < WAIT_W'(RD_LATENCY));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            rd_wait_cnt <= '0;
            cmd_rdy     <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            pgd_out     <= 1'b0;
            pgd_oe      <= 1'b0;
            cpu_hold    <= 1'b0;
            busy        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
        end else begin
            shift_reg   <= shift_reg_d;
            bit_cnt     <= bit_cnt_d;
            rd_wait_cnt <= rd_wait_cnt_d;
            cmd_rdy     <= cmd_rdy_d;
            mem_addr    <= mem_addr_d;
            mem_wr_data <= mem_wr_data_d;
            pgd_out     <= pgd_out_d;
            pgd_oe      <= pgd_oe_d;
            cpu_hold    <= cpu_hold_d;
            busy        <= busy_d;
            mem_wr_en   <= mem_wr_en_d;
            mem_rd_en   <= mem_rd_en_d;
        end
    end

endmodule
